// File: rtl/serial_word_rx.sv
// Framed serial word receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_WORD_RX_PARITY_EN to compile in the parity stage; otherwise parity_err is tied to 0.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | line idle, waiting for a start bit (sin=0)
// S_DATA      | shifting in WIDTH data bits, LSB first
// S_PARITY    | sampling the even-parity bit (parity build only)
// S_STOP      | sampling the stop bit; deliver word or report an error
// S_WAIT_IDLE | stop bit was low; wait for the line to return high
module serial_word_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_q;
  logic             par_bad_q;
  logic             word_good, stop_bad, par_fail;
  logic             deliver, drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word_good = 1'b0;
    stop_bad  = 1'b0;
    par_fail  = 1'b0;
    case (state)
      S_IDLE:
        if (!sin) state_nxt = S_DATA;
      S_DATA:
        if (bit_cnt == LAST_IDX) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      S_PARITY:
        state_nxt = S_STOP;
      S_STOP:
        if (sin) begin
          state_nxt = S_IDLE;
          if (par_bad_q) par_fail  = 1'b1;
          else           word_good = 1'b1;
        end else begin
          stop_bad  = 1'b1;
          state_nxt = S_WAIT_IDLE;
        end
      S_WAIT_IDLE:
        if (sin) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // A full holding register may still take a new word if it is being consumed on this edge.
  assign deliver = word_good && (!out_valid || out_ready);
  assign drop    = word_good && out_valid && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= stop_bad;
      parity_err <= par_fail;
      overrun    <= drop;
      busy       <= (state_nxt != S_IDLE);
      if (state == S_IDLE) bit_cnt <= '0;
      if (state == S_DATA) begin
        shift_q <= {sin, shift_q[WIDTH-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (deliver) begin
        out_data  <= shift_q;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_WORD_RX_PARITY_EN
  // Even parity over data plus parity bit must XOR to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  par_bad_q <= 1'b0;
    else if (state == S_PARITY) par_bad_q <= ^{shift_q, sin};
  end
`else
  assign par_bad_q = 1'b0;
`endif

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Downstream consumer of the 4-bit serial shift register's serial bit stream.
- Receives framed serial data at one bit per clock on sin: start bit, WIDTH data bits LSB first, optional even-parity bit, stop bit.
- Presents each good word on a one-entry output holding register with a valid/ready handshake.
- Flags framing errors, parity errors and overruns to the control block.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..16).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial line; idles high.
- out_data  output  WIDTH  received word, stable while out_valid=1.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts the word on a clock edge where out_valid=1 and out_ready=1.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- overrun  output  1  one-cycle pulse: good word dropped because the holding register was full.

Behaviour:
- Reset (asynchronous, while reset=1):
  - state=IDLE, bit counter=0, shift register=0.
  - out_data=0, out_valid=0, busy=0, frame_err=0, parity_err=0, overrun=0.
  - Reset mid-frame aborts the frame; no word or error is reported.
- All outputs are registered. sin is sampled once per posedge; there is no oversampling.
- IDLE:
  - sin=0 is taken as the start bit -> DATA, counter=0.
  - sin=1 -> stay in IDLE.
- DATA:
  - Each edge shifts sin into bit [counter] (LSB first), counter+1.
  - After the WIDTH-th bit: -> PARITY if the optional feature is compiled in, else -> STOP.
- PARITY: sample the parity bit; compute mismatch against even parity over data plus parity bit; -> STOP.
- STOP, sampled sin=1:
  - With parity mismatch: pulse parity_err, discard the word, -> IDLE.
  - Otherwise deliver the word, -> IDLE.
- STOP, sampled sin=0: pulse frame_err, discard the word, -> WAIT_IDLE.
- WAIT_IDLE: stay until sin=1, then -> IDLE. A held-low line must not be taken as a new start bit.
- Delivery on the STOP edge:
  - If out_valid=0, or out_valid=1 with out_ready=1 on the same edge: load out_data and set out_valid=1.
  - Simultaneous accept and delivery therefore keeps out_valid=1 with the new data.
  - Otherwise keep the old word, drop the new one, and pulse overrun.
- Handshake:
  - out_valid falls on the edge where out_ready=1, unless a delivery occurs on that edge.
  - out_ready while out_valid=0 has no effect.
- Latency: with the start bit sampled on edge 0, out_valid rises on edge WIDTH+1 (no parity) or WIDTH+2 (parity).
- Back-to-back frames: a start bit may be sampled on the edge immediately after STOP. There is no mandatory idle gap.
- Error pulses last exactly one cycle; at most one error pulse per frame.

Optional Feature:
- Macro: SERIAL_WORD_RX_PARITY_EN.
- Defined:
  - PARITY state is present; frames are WIDTH+3 bits.
  - Even-parity check as above.
- Undefined:
  - No PARITY state; frames are WIDTH+2 bits.
  - parity_err is tied to 0.
  - The port list is identical in both builds.

Test Plan (WIDTH=8):
- Reset then idle: reset=1 for 5 cycles, sin=1 for 20 cycles -> all outputs 0 throughout, state remains IDLE.
- Good frame, parity disabled: sin = 0, then 1,0,1,0,0,1,0,1, then 1 -> out_data=8'hA5; out_valid rises on edge 9; it falls on the edge after out_ready=1.
- Back-to-back with overrun: two consecutive frames 8'h3C, 8'hC3 with out_ready=0 -> out_data stays 8'h3C, out_valid=1, overrun pulses once at the second STOP edge. Repeat with out_ready=1 on that edge -> out_data=8'hC3, no overrun.
- Framing error: frame 8'hFF with stop bit 0, then sin=0 for 5 more cycles, then 1 -> frame_err single pulse, out_valid stays 0, busy stays high until sin returns to 1, no spurious start.
- Parity build: frame 8'h01 with parity bit 1 -> out_data=8'h01. Same frame with parity bit 0 -> parity_err pulse and no delivery.
- Reset mid-frame: assert reset after the 4th data bit of 8'h5A, release, then send a full 8'h5A frame -> only one delivery, out_data=8'h5A, no error pulses.
